// File: rtl/otter_decode_ctrl_if.sv
// Fetch-to-execute handshake bundle for otter_decode_ctrl.
// The slave modport is the decoder; the master modport drives fetch and execute.
interface otter_decode_ctrl_if #(
   parameter int unsigned XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [XLEN-1:0] i_instrn;
   logic [XLEN-1:0] i_pc;
   logic            i_flush;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_instrn;
   logic [XLEN-1:0] o_pc;
   logic [XLEN-1:0] o_immed;
   logic [2:0]      o_imm_sel;
   logic            o_illegal;

   modport slave (
      input  i_valid, i_instrn, i_pc, i_flush, i_ready,
      output o_ready, o_valid, o_instrn, o_pc, o_immed, o_imm_sel, o_illegal
   );

   modport master (
      output i_valid, i_instrn, i_pc, i_flush, i_ready,
      input  o_ready, o_valid, o_instrn, o_pc, o_immed, o_imm_sel, o_illegal
   );
endinterface

// File: rtl/otter_decode_ctrl.sv
// Decode sequencer: classifies fetched opcodes, generates immediates and
// queues results in a 2-entry skid buffer toward execute.
package otter_decode_pkg;
   typedef enum logic [2:0] {
      IMM_GEN_SEL_I_TYPE = 3'd0,
      IMM_GEN_SEL_S_TYPE = 3'd1,
      IMM_GEN_SEL_BRANCH = 3'd2,
      IMM_GEN_SEL_UPPER  = 3'd3,
      IMM_GEN_SEL_JUMP   = 3'd4
   } imm_sel_e;
endpackage

module otter_imm_gen #(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:7]     ir_i,
   input  logic [2:0]      sel_i,
   output logic [XLEN-1:0] immed_o
);
   import otter_decode_pkg::*;

   always_comb begin
      immed_o = '0;
      unique case (sel_i)
         IMM_GEN_SEL_I_TYPE: immed_o = {{(XLEN-11){ir_i[31]}}, ir_i[30:20]};
         IMM_GEN_SEL_S_TYPE: immed_o = {{(XLEN-11){ir_i[31]}}, ir_i[30:25], ir_i[11:7]};
         IMM_GEN_SEL_BRANCH: immed_o = {{(XLEN-12){ir_i[31]}}, ir_i[7], ir_i[30:25],
                                        ir_i[11:8], 1'b0};
         IMM_GEN_SEL_UPPER:  immed_o = {{(XLEN-31){ir_i[31]}}, ir_i[30:12], 12'b0};
         IMM_GEN_SEL_JUMP:   immed_o = {{(XLEN-20){ir_i[31]}}, ir_i[19:12], ir_i[20],
                                        ir_i[30:21], 1'b0};
         default:            immed_o = '0;
      endcase
   end
endmodule

module otter_decode_ctrl #(
   parameter int unsigned XLEN            = 32,
   parameter bit          ILLEGAL_TRAP_EN = 1'b1
) (
   input logic                i_clk,
   input logic                i_rst,
   otter_decode_ctrl_if.slave bus
);
   import otter_decode_pkg::*;

   typedef struct packed {
      logic [XLEN-1:0] instrn;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] immed;
      logic [2:0]      sel;
      logic            illegal;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            head_q, head_d;
   logic            tail_q, tail_d;
   entry_t          mem_q [2];

   logic [6:0]      opcode;
   imm_sel_e        dec_sel;
   logic            dec_zero_imm;
   logic            dec_illegal;
   logic [XLEN-1:0] gen_immed;
   entry_t          in_entry;
   entry_t          head_entry;
   logic            push, pop;

   assign opcode = bus.i_instrn[6:0];

   always_comb begin
      dec_sel      = IMM_GEN_SEL_I_TYPE;
      dec_zero_imm = 1'b0;
      dec_illegal  = 1'b0;
      unique case (opcode)
         7'b0110111, 7'b0010111: dec_sel = IMM_GEN_SEL_UPPER;
         7'b1101111:             dec_sel = IMM_GEN_SEL_JUMP;
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b1110011, 7'b0001111: dec_sel = IMM_GEN_SEL_I_TYPE;
         7'b0100011:             dec_sel = IMM_GEN_SEL_S_TYPE;
         7'b1100011:             dec_sel = IMM_GEN_SEL_BRANCH;
         7'b0110011:             dec_zero_imm = 1'b1;
         default: begin
            dec_zero_imm = 1'b1;
            dec_illegal  = ILLEGAL_TRAP_EN;
         end
      endcase
   end

   otter_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .ir_i    (bus.i_instrn[31:7]),
      .sel_i   (dec_sel),
      .immed_o (gen_immed)
   );

   always_comb begin
      in_entry.instrn  = bus.i_instrn;
      in_entry.pc      = bus.i_pc;
      in_entry.immed   = dec_zero_imm ? '0 : gen_immed;
      in_entry.sel     = dec_sel;
      in_entry.illegal = dec_illegal;
   end

   // Ready comes only from registered occupancy, never from i_ready.
   assign bus.o_ready = (state_q != S_FULL);
   assign bus.o_valid = (state_q != S_EMPTY);
   assign push        = bus.i_valid & bus.o_ready & ~bus.i_flush;
   assign pop         = bus.o_valid & bus.i_ready & ~bus.i_flush;

   always_comb begin
      state_d = state_q;
      head_d  = head_q ^ pop;
      tail_d  = tail_q ^ push;
      if (bus.i_flush) begin
         state_d = S_EMPTY;
         head_d  = 1'b0;
         tail_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_EMPTY: if (push)         state_d = S_ONE;
            S_ONE:   if (push && !pop) state_d = S_FULL;
                     else if (!push && pop) state_d = S_EMPTY;
            S_FULL:  if (pop)          state_d = S_ONE;
            default:                   state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_EMPTY;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[tail_q] <= in_entry;
   end

   // Storage is never cleared, so the head is masked to zero while empty.
   assign head_entry    = bus.o_valid ? mem_q[head_q] : '0;
   assign bus.o_instrn  = head_entry.instrn;
   assign bus.o_pc      = head_entry.pc;
   assign bus.o_immed   = head_entry.immed;
   assign bus.o_imm_sel = head_entry.sel;
   assign bus.o_illegal = head_entry.illegal;
endmodule

// File: tb/tb_otter_decode_ctrl.sv
// Directed bench for otter_decode_ctrl: decode, streaming, backpressure,
// flush, illegal opcodes (trap on/off) and asynchronous reset.
module tb_otter_decode_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   localparam logic [2:0] SEL_I = 3'd0, SEL_S = 3'd1, SEL_B = 3'd2,
                          SEL_U = 3'd3, SEL_J = 3'd4;

   otter_decode_ctrl_if #(.XLEN(32)) bus0 ();
   otter_decode_ctrl_if #(.XLEN(32)) bus1 ();

   otter_decode_ctrl #(.XLEN(32), .ILLEGAL_TRAP_EN(1'b1)) dut_trap (
      .i_clk (clk), .i_rst (rst), .bus (bus0.slave)
   );
   otter_decode_ctrl #(.XLEN(32), .ILLEGAL_TRAP_EN(1'b0)) dut_notrap (
      .i_clk (clk), .i_rst (rst), .bus (bus1.slave)
   );

   assign bus1.i_valid  = bus0.i_valid;
   assign bus1.i_instrn = bus0.i_instrn;
   assign bus1.i_pc     = bus0.i_pc;
   assign bus1.i_flush  = bus0.i_flush;
   assign bus1.i_ready  = bus0.i_ready;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit (got timeout, need finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [2:0] sel, input logic ill);
      chk({tag, ".valid"},   64'(bus0.o_valid),   64'(1'b1));
      chk({tag, ".instrn"},  64'(bus0.o_instrn),  64'(instr));
      chk({tag, ".pc"},      64'(bus0.o_pc),      64'(pc));
      chk({tag, ".immed"},   64'(bus0.o_immed),   64'(imm));
      chk({tag, ".sel"},     64'(bus0.o_imm_sel), 64'(sel));
      chk({tag, ".illegal"}, 64'(bus0.o_illegal), 64'(ill));
   endtask

   task automatic check_empty(input string tag);
      chk({tag, ".valid"},  64'(bus0.o_valid),   64'(1'b0));
      chk({tag, ".ready"},  64'(bus0.o_ready),   64'(1'b1));
      chk({tag, ".instrn"}, 64'(bus0.o_instrn),  64'(0));
      chk({tag, ".pc"},     64'(bus0.o_pc),      64'(0));
      chk({tag, ".immed"},  64'(bus0.o_immed),   64'(0));
      chk({tag, ".sel"},    64'(bus0.o_imm_sel), 64'(0));
      chk({tag, ".ill"},    64'(bus0.o_illegal), 64'(0));
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
      bus0.i_valid  = 1'b1;
      bus0.i_instrn = instr;
      bus0.i_pc     = pc;
   endtask

   logic [31:0] s_instr [4] = '{32'h12345037, 32'h0080006F, 32'hFE000EE3, 32'h0020A423};
   logic [31:0] s_imm   [4] = '{32'h12345000, 32'h00000008, 32'hFFFFFFFC, 32'h00000008};
   logic [2:0]  s_sel   [4] = '{SEL_U, SEL_J, SEL_B, SEL_S};

   initial begin
      bus0.i_valid  = 1'b0;
      bus0.i_instrn = '0;
      bus0.i_pc     = '0;
      bus0.i_flush  = 1'b0;
      bus0.i_ready  = 1'b0;

      // Reset state
      step();
      step();
      check_empty("reset");
      rst = 1'b0;
      step();

      // Single ADDI, one-cycle latency
      bus0.i_ready = 1'b1;
      offer(32'hFFF00093, 32'h0000_0100);
      step();
      bus0.i_valid = 1'b0;
      check_head("addi", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, SEL_I, 1'b0);
      step();
      check_empty("addi_drain");

      // Back-to-back stream with execute always ready
      for (int i = 0; i < 4; i++) begin
         offer(s_instr[i], 32'h0000_0200 + 32'(4 * i));
         step();
         check_head($sformatf("stream%0d", i), s_instr[i], 32'h200 + 32'(4 * i),
                    s_imm[i], s_sel[i], 1'b0);
         chk($sformatf("stream%0d.ready", i), 64'(bus0.o_ready), 64'(1'b1));
      end
      bus0.i_valid = 1'b0;
      step();
      check_empty("stream_drain");

      // Backpressure: three offered, two accepted
      bus0.i_ready = 1'b0;
      offer(32'h00100113, 32'h300);           // addi x2,x0,1 -> imm 1
      step();
      chk("bp_ready1", 64'(bus0.o_ready), 64'(1'b1));
      offer(32'h00200193, 32'h304);           // addi x3,x0,2 -> imm 2
      step();
      chk("bp_ready2", 64'(bus0.o_ready), 64'(1'b0));
      offer(32'h00300213, 32'h308);           // addi x4,x0,3 -> imm 3
      step();
      chk("bp_ready3", 64'(bus0.o_ready), 64'(1'b0));
      check_head("bp_hold", 32'h00100113, 32'h300, 32'h1, SEL_I, 1'b0);
      bus0.i_ready = 1'b1;
      step();
      check_head("bp_out2", 32'h00200193, 32'h304, 32'h2, SEL_I, 1'b0);
      step();
      bus0.i_valid = 1'b0;
      check_head("bp_out3", 32'h00300213, 32'h308, 32'h3, SEL_I, 1'b0);
      step();
      check_empty("bp_drain");

      // Flush with buffer full and a beat offered
      bus0.i_ready = 1'b0;
      offer(32'h00500293, 32'h400);
      step();
      offer(32'h00600313, 32'h404);
      step();
      chk("fl_full", 64'(bus0.o_ready), 64'(1'b0));
      offer(32'h00700393, 32'h408);
      bus0.i_flush = 1'b1;
      step();
      bus0.i_flush = 1'b0;
      bus0.i_valid = 1'b0;
      check_empty("flush");
      bus0.i_ready = 1'b1;
      step();
      check_empty("flush_after");

      // Illegal opcode, trap enabled vs disabled; OP forces zero immediate
      offer(32'h0000007F, 32'h500);
      step();
      bus0.i_valid = 1'b0;
      chk("ill_trap.illegal", 64'(bus0.o_illegal), 64'(1'b1));
      chk("ill_trap.immed",   64'(bus0.o_immed),   64'(0));
      chk("ill_notrap.valid", 64'(bus1.o_valid),   64'(1'b1));
      chk("ill_notrap.ill",   64'(bus1.o_illegal), 64'(1'b0));
      chk("ill_notrap.immed", 64'(bus1.o_immed),   64'(0));
      offer(32'h40208033, 32'h504);           // sub x0,x1,x2
      step();
      bus0.i_valid = 1'b0;
      check_head("op_sub", 32'h40208033, 32'h504, 32'h0, SEL_I, 1'b0);
      step();

      // Asynchronous reset mid-stall with buffer full
      bus0.i_ready = 1'b0;
      offer(32'h00800413, 32'h600);
      step();
      offer(32'h00900493, 32'h604);
      step();
      bus0.i_valid = 1'b0;
      chk("ar_full", 64'(bus0.o_ready), 64'(1'b0));
      #2;
      rst = 1'b1;
      #1;
      check_empty("async_rst");
      #1;
      rst = 1'b0;
      step();
      check_empty("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
